// File: rtl/instr_sequencer.sv
// Multi-cycle Moore sequencer for the 16-bit RISC datapath: fetch, decode dispatch,
// ALU sequencing and LDR/STR memory access, plus a companion invariant checker.
module instr_sequencer #(
  parameter int STATE_W         = 5,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       reset_pc,
  output logic       load_pc,
  output logic       load_ir,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic [2:0] nsel,
  output logic [3:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       halted
);

  typedef enum logic [STATE_W-1:0] {
    S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_MOV_IMM, S_GET_A, S_GET_B,
    S_PASS, S_EXEC, S_WRITE_REG, S_COMPARE, S_ADDR, S_LOAD_ADDR, S_MEM_RD1,
    S_MEM_RD2, S_GET_RD, S_PASS_RD, S_MEM_WR, S_HALT
  } state_t;

  localparam logic [4:0] I_MOV_IMM = 5'b110_10;
  localparam logic [4:0] I_MOV_REG = 5'b110_00;
  localparam logic [4:0] I_ADD     = 5'b101_00;
  localparam logic [4:0] I_CMP     = 5'b101_01;
  localparam logic [4:0] I_AND     = 5'b101_10;
  localparam logic [4:0] I_MVN     = 5'b101_11;
  localparam logic [4:0] I_LDR     = 5'b011_00;
  localparam logic [4:0] I_STR     = 5'b100_00;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_instr;
  logic [4:0] w_instr;

  assign w_instr = {opcode, op};

  // Decoder inputs may change after DECODE, so the dispatched instruction is latched there.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RST;
      r_instr <= 5'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_instr <= w_instr;
      end else begin
        r_instr <= r_instr;
      end
    end
  end

  always_comb begin
    w_next = S_HALT;
    case (r_state)
      S_RST:       w_next = S_IF1;
      S_IF1:       w_next = S_IF2;
      S_IF2:       w_next = S_UPDATE_PC;
      S_UPDATE_PC: w_next = S_DECODE;
      S_DECODE: begin
        case (w_instr)
          I_MOV_IMM:                            w_next = S_MOV_IMM;
          I_MOV_REG, I_MVN:                     w_next = S_GET_B;
          I_ADD, I_AND, I_CMP, I_LDR, I_STR:    w_next = S_GET_A;
          default: begin
            if (opcode == 3'b111) begin
              w_next = S_HALT;
            end else if (HALT_ON_ILLEGAL) begin
              w_next = S_HALT;
            end else begin
              w_next = S_IF1;
            end
          end
        endcase
      end
      S_MOV_IMM: w_next = S_IF1;
      S_GET_A: begin
        if ((r_instr == I_LDR) || (r_instr == I_STR)) begin
          w_next = S_ADDR;
        end else begin
          w_next = S_GET_B;
        end
      end
      S_GET_B: begin
        case (r_instr)
          I_MOV_REG: w_next = S_PASS;
          I_CMP:     w_next = S_COMPARE;
          default:   w_next = S_EXEC;
        endcase
      end
      S_PASS:      w_next = S_WRITE_REG;
      S_EXEC:      w_next = S_WRITE_REG;
      S_WRITE_REG: w_next = S_IF1;
      S_COMPARE:   w_next = S_IF1;
      S_ADDR:      w_next = S_LOAD_ADDR;
      S_LOAD_ADDR: begin
        if (r_instr == I_STR) begin
          w_next = S_GET_RD;
        end else begin
          w_next = S_MEM_RD1;
        end
      end
      S_MEM_RD1:   w_next = S_MEM_RD2;
      S_MEM_RD2:   w_next = S_IF1;
      S_GET_RD:    w_next = S_PASS_RD;
      S_PASS_RD:   w_next = S_MEM_WR;
      S_MEM_WR:    w_next = S_IF1;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_HALT;
    endcase
  end

  // Moore output decode; everything not named for a state stays 0.
  always_comb begin
    reset_pc  = 1'b0;
    load_pc   = 1'b0;
    load_ir   = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = 2'b00;
    nsel      = 3'b000;
    vsel      = 4'b0000;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    halted    = 1'b0;
    case (r_state)
      S_RST:       begin reset_pc = 1'b1; load_pc = 1'b1; end
      S_IF1:       begin addr_sel = 1'b1; mem_cmd = 2'b01; end
      S_IF2:       begin addr_sel = 1'b1; mem_cmd = 2'b01; load_ir = 1'b1; end
      S_UPDATE_PC: load_pc = 1'b1;
      S_DECODE:    halted = 1'b0;
      S_MOV_IMM:   begin nsel = 3'b100; vsel = 4'b0100; write = 1'b1; end
      S_GET_A:     begin nsel = 3'b100; loada = 1'b1; end
      S_GET_B:     begin nsel = 3'b001; loadb = 1'b1; end
      S_PASS:      begin asel = 1'b1; loadc = 1'b1; end
      S_EXEC:      loadc = 1'b1;
      S_WRITE_REG: begin nsel = 3'b010; vsel = 4'b0001; write = 1'b1; end
      S_COMPARE:   loads = 1'b1;
      S_ADDR:      begin bsel = 1'b1; loadc = 1'b1; end
      S_LOAD_ADDR: load_addr = 1'b1;
      S_MEM_RD1:   mem_cmd = 2'b01;
      S_MEM_RD2:   begin mem_cmd = 2'b01; nsel = 3'b010; vsel = 4'b1000; write = 1'b1; end
      S_GET_RD:    begin nsel = 3'b010; loadb = 1'b1; end
      S_PASS_RD:   begin asel = 1'b1; loadc = 1'b1; end
      S_MEM_WR:    mem_cmd = 2'b10;
      S_HALT:      halted = 1'b1;
      default:     halted = 1'b0;
    endcase
  end

endmodule

// Invariant checker for instr_sequencer outputs; armed by the first reset.
module instr_sequencer_chk (
  input logic       clk,
  input logic       reset,
  input logic       load_pc,
  input logic       load_ir,
  input logic       load_addr,
  input logic [1:0] mem_cmd,
  input logic [2:0] nsel,
  input logic [3:0] vsel,
  input logic       write,
  input logic       loada,
  input logic       loadb
);

  logic r_armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_armed <= 1'b1;
    end else begin
      r_armed <= r_armed;
    end
  end

  always @(posedge clk) begin
    if (r_armed) begin
      a_mem_cmd : assert (mem_cmd != 2'b11);
      a_wr_ir   : assert (!(write && load_ir));
      a_loads   : assert ($countones({load_pc, load_ir, load_addr}) <= 1);
      a_nsel    : assert ($onehot0(nsel));
      a_vsel    : assert ($onehot0(vsel));
      a_nsel_en : assert (!(write || loada || loadb) || (nsel != 3'b000));
    end
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle instruction sequencer for the 16-bit RISC datapath.
- Replaces the standalone wait/decode controller: owns fetch (PC, instruction register, memory read), decode dispatch, register-file/ALU sequencing, and LDR/STR memory access.
- Sits between the instruction decoder (supplies opcode/op) and the datapath, PC/address registers and the memory command bus.
- Runs autonomously from reset until a HALT instruction.

Parameters:
- STATE_W, 5, width of state register; must encode all 20 states below.
- HALT_ON_ILLEGAL, 1, when 1 an undefined {opcode,op} goes to HALT; when 0 it returns to IF1, treated as a NOP.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  3  instruction bits [15:13] from the IR decoder
- op  in  2  instruction bits [12:11] from the IR decoder
- reset_pc  out  1  selects 0 as the next PC value
- load_pc  out  1  PC register enable
- load_ir  out  1  instruction register enable
- addr_sel  out  1  memory address mux: 1 = PC, 0 = data address register
- load_addr  out  1  data address register enable, loaded from datapath C[8:0]
- mem_cmd  out  2  00 none, 01 read, 10 write; 11 never driven
- nsel  out  3  one-hot register select: 100 Rn, 010 Rd, 001 Rm
- vsel  out  4  one-hot writeback source: 0001 C, 0010 PC, 0100 sximm8, 1000 mdata
- write  out  1  register file write enable
- loada, loadb, loadc, loads  out  1 each  datapath register enables
- asel  out  1  1 = zero into ALU A input
- bsel  out  1  1 = sximm5 into ALU B input
- halted  out  1  high only in HALT

Behaviour:
- Moore machine: outputs decode from the registered state only.
- Any output not listed for a state is 0, including nsel, vsel, asel and bsel. No X is ever driven.
- Reset: at a clk edge with reset=1, state <= RST, regardless of current state (mid-instruction, HALT, anything).
- Outputs during the reset cycle reflect the pre-reset state. RST's outputs appear the following cycle.
- Common fetch path:
  - RST: reset_pc=1, load_pc=1 -> IF1
  - IF1: addr_sel=1, mem_cmd=01 -> IF2
  - IF2: addr_sel=1, mem_cmd=01, load_ir=1 -> UPDATE_PC
  - UPDATE_PC: load_pc=1 -> DECODE
  - DECODE: no outputs; dispatches on {opcode,op}, which are valid from this cycle.
- Dispatch from DECODE ({opcode,op} -> path):
  - 110,10 MOV imm -> MOV_IMM (nsel=100, vsel=0100, write) -> IF1.
  - 110,00 MOV reg -> GET_B (nsel=001, loadb) -> PASS (asel=1, loadc) -> WRITE_REG (nsel=010, vsel=0001, write) -> IF1.
  - 101,00 ADD / 101,10 AND -> GET_A (nsel=100, loada) -> GET_B -> EXEC (loadc) -> WRITE_REG -> IF1.
  - 101,11 MVN -> GET_B -> EXEC -> WRITE_REG -> IF1. GET_A is skipped.
  - 101,01 CMP -> GET_A -> GET_B -> COMPARE (loads; loadc=0) -> IF1.
  - 011,00 LDR -> GET_A -> ADDR (bsel=1, loadc) -> LOAD_ADDR (load_addr) -> MEM_RD1 (addr_sel=0, mem_cmd=01) -> MEM_RD2 (addr_sel=0, mem_cmd=01, nsel=010, vsel=1000, write) -> IF1.
  - 100,00 STR -> GET_A -> ADDR -> LOAD_ADDR -> GET_RD (nsel=010, loadb) -> PASS_RD (asel=1, loadc) -> MEM_WR (addr_sel=0, mem_cmd=10) -> IF1.
  - 111,xx HALT -> HALT.
  - Any other encoding -> HALT if HALT_ON_ILLEGAL, else IF1.
- HALT: halted=1, all other outputs 0. Self-loop; only reset exits.
- Cycle count per instruction, counted from IF1 up to the next IF1:
  - MOV imm 5
  - MOV reg 7
  - MVN 7
  - CMP 7
  - ADD/AND 8
  - LDR 9
  - STR 10
- Invariants, asserted every cycle:
  - mem_cmd != 11.
  - write and load_ir are never both 1.
  - At most one of load_pc, load_ir, load_addr is 1.
  - nsel and vsel are one-hot or zero.
  - nsel is nonzero whenever write, loada or loadb is 1.

Test Plan:
- Reset, then opcode=110/op=10 held -> trace RST, IF1, IF2 (load_ir=1), UPDATE_PC (load_pc=1), DECODE, MOV_IMM (write=1, vsel=0100, nsel=100), IF1; 5 cycles from IF1 to IF1.
- ADD (101/00) -> loada with nsel=100, then loadb with nsel=001, then loadc with asel=0/bsel=0, then write with vsel=0001/nsel=010; next IF1 exactly 8 cycles after the prior IF1. CMP (101/01) -> loads=1, loadc=0, write never 1.
- LDR (011/00) -> ADDR has bsel=1; load_addr pulses once; mem_cmd=01 with addr_sel=0 for 2 cycles; write=1 with vsel=1000 in the second. STR (100/00) -> single mem_cmd=10 cycle with addr_sel=0, write never 1.
- HALT (111/xx) -> halted=1 held for 50 cycles, all other outputs 0; assert reset 1 cycle -> RST next, then fetch resumes with addr_sel=1, mem_cmd=01.
- Reset asserted in MEM_RD1 and again in EXEC -> next state RST; write never pulses after reset is sampled. Illegal 000/00 with HALT_ON_ILLEGAL=1 -> halted; with HALT_ON_ILLEGAL=0 -> IF1 after DECODE.
- Random opcode/op stream for 10k cycles -> all invariants hold; no X on any output after the first reset.
